// File: rtl/vx_cache_rsp_buffer.sv
// Per-lane response buffer between cache banks and the core response port.
// Each lane is an independent DEPTH-entry FIFO of {data, tag} whose head is presented directly from storage.
module vx_cache_rsp_buffer #(
   parameter int unsigned NUM_REQS   = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQS-1:0]            in_valid_i,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data_i,
   input  logic [NUM_REQS*TAG_WIDTH-1:0]  in_tag_i,
   output logic [NUM_REQS-1:0]            in_ready_o,
   output logic [NUM_REQS-1:0]            rsp_valid_o,
   output logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_o,
   output logic [NUM_REQS*TAG_WIDTH-1:0]  rsp_tag_o,
   input  logic [NUM_REQS-1:0]            rsp_ready_i,
   output logic                           idle_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] data_q [NUM_REQS][DEPTH];
   logic [TAG_WIDTH-1:0]  tag_q  [NUM_REQS][DEPTH];
   logic [AW-1:0]         wr_ptr_q [NUM_REQS];
   logic [AW-1:0]         wr_ptr_d [NUM_REQS];
   logic [AW-1:0]         rd_ptr_q [NUM_REQS];
   logic [AW-1:0]         rd_ptr_d [NUM_REQS];
   logic [CW-1:0]         count_q  [NUM_REQS];
   logic [CW-1:0]         count_d  [NUM_REQS];
   logic [NUM_REQS-1:0]   push_c;
   logic [NUM_REQS-1:0]   pop_c;

   // Handshakes and pointer/count next state; a full lane never takes a push, even while popping
   always_comb begin
      push_c = '0;
      pop_c  = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         count_d[i]  = count_q[i];
         push_c[i]   = in_valid_i[i] && (count_q[i] != CW'(DEPTH));
         pop_c[i]    = rsp_ready_i[i] && (count_q[i] != CW'(0));
         if (push_c[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
         if (pop_c[i])  rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
         case ({push_c[i], pop_c[i]})
            2'b10:   count_d[i] = count_q[i] + CW'(1);
            2'b01:   count_d[i] = count_q[i] - CW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
               data_q[i][k] <= '0;
               tag_q[i][k]  <= '0;
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQS; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
            if (push_c[i]) begin
               data_q[i][wr_ptr_q[i]] <= in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
               tag_q[i][wr_ptr_q[i]]  <= in_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
            end
         end
      end
   end

   // Outputs depend on registered state only
   always_comb begin
      in_ready_o  = '0;
      rsp_valid_o = '0;
      rsp_data_o  = '0;
      rsp_tag_o   = '0;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
         in_ready_o[i]  = (count_q[i] != CW'(DEPTH));
         rsp_valid_o[i] = (count_q[i] != CW'(0));
         rsp_data_o[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i][rd_ptr_q[i]];
         rsp_tag_o[i*TAG_WIDTH +: TAG_WIDTH]    = tag_q[i][rd_ptr_q[i]];
      end
      idle_o = ~(|rsp_valid_o);
   end

endmodule
